// File: rtl/truth_table_sweeper.sv
// Steps a 3-input combinational function through all eight input vectors.
// Each vector is held for DWELL cycles, the response is recorded, and the recorded table is compared with an expected table.
module truth_table_sweeper #(
  parameter int DWELL = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       f_in,
  input  logic [7:0] exp_table,
  output logic       a_out,
  output logic       b_out,
  output logic       c_out,
  output logic       busy,
  output logic       done,
  output logic [7:0] table_out,
  output logic       pass
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

  state_t     state;
  logic [2:0] vec;
  logic [7:0] dwell_cnt;
  logic [7:0] exp_lat;
  logic [7:0] table_next;

  // The vector register drives A/B/C directly, so the pins change only on clock edges.
  assign a_out = vec[2];
  assign b_out = vec[1];
  assign c_out = vec[0];

  // The table including the bit being captured on this edge, so pass is valid in the FIN cycle.
  always_comb begin
    table_next      = table_out;
    table_next[vec] = f_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      vec       <= 3'd0;
      dwell_cnt <= 8'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      table_out <= 8'h00;
      pass      <= 1'b0;
      exp_lat   <= 8'h00;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          vec  <= 3'd0;
          busy <= 1'b0;
          if (start) begin
            state     <= RUN;
            busy      <= 1'b1;
            dwell_cnt <= 8'd0;
            table_out <= 8'h00;
            pass      <= 1'b0;
            exp_lat   <= exp_table;
          end
        end
        RUN: begin
          if (dwell_cnt == DWELL_LAST) begin
            table_out <= table_next;
            dwell_cnt <= 8'd0;
            if (vec == 3'd7) begin
              state <= FIN;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (table_next == exp_lat);
            end else begin
              vec <= vec + 3'd1;
            end
          end else begin
            dwell_cnt <= dwell_cnt + 8'd1;
          end
        end
        FIN: begin
          state <= IDLE;
          vec   <= 3'd0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Self-checking bench for truth_table_sweeper: majority function at DWELL=10 and constant-1 function at DWELL=2.
// Expected {table, pass} entries are queued at start and popped when done is seen.
module tb_truth_table_sweeper;

  logic clk = 1'b0;
  logic rst_n;
  logic start, start2;
  logic [7:0] exp_table, exp2;
  logic f_in;
  logic a_out, b_out, c_out, busy, done, pass;
  logic [7:0] table_out;
  logic a2, b2, c2, busy2, done2, pass2;
  logic [7:0] table2;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [7:0] tbl;
    logic       pas;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  logic glitch_en = 1'b0;
  logic glitch    = 1'b0;
  int   gcnt      = 0;
  logic [3:0] prev_key = 4'd0;

  always #5 clk = ~clk;

  truth_table_sweeper #(.DWELL(10)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .f_in(f_in), .exp_table(exp_table),
    .a_out(a_out), .b_out(b_out), .c_out(c_out), .busy(busy), .done(done),
    .table_out(table_out), .pass(pass)
  );

  truth_table_sweeper #(.DWELL(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .f_in(1'b1), .exp_table(exp2),
    .a_out(a2), .b_out(b2), .c_out(c2), .busy(busy2), .done(done2),
    .table_out(table2), .pass(pass2)
  );

  function automatic logic maj(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic [7:0] maj_table();
    logic [7:0] t;
    logic [2:0] v;
    for (int i = 0; i < 8; i++) begin
      v    = 3'(i);
      t[i] = maj(v[2], v[1], v[0]);
    end
    return t;
  endfunction

  // Function under test; in glitch mode the response toggles during all but the last cycle of each vector.
  assign f_in = maj(a_out, b_out, c_out) ^ (glitch_en & glitch);

  always @(negedge clk) begin
    if ({busy, a_out, b_out, c_out} != prev_key) gcnt = 1;
    else gcnt = gcnt + 1;
    prev_key = {busy, a_out, b_out, c_out};
    glitch = (gcnt < 10) ? gcnt[0] : 1'b0;
  end

  // Called one negedge after the start edge; returns the cycle at which done was seen.
  task automatic wait_done(output int lat);
    lat = 1;
    while (done !== 1'b1 && lat < 2000) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic pulse_start(input logic [7:0] x, input logic exp_pass);
    @(negedge clk);
    exp_table = x;
    start     = 1'b1;
    sb.push_back('{tbl: maj_table(), pas: exp_pass});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    tests++; if ({a_out, b_out, c_out} !== 3'b000) begin fails++; $display("FAIL reset_vec got %b want 000", {a_out, b_out, c_out}); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done); end
    tests++; if (table_out !== 8'h00) begin fails++; $display("FAIL reset_table got %h want 00", table_out); end
    tests++; if (pass !== 1'b0) begin fails++; $display("FAIL reset_pass got %b want 0", pass); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_majority();
    int n;
    logic [2:0] wv;
    pulse_start(8'hE8, 1'b1);
    n = 1;
    while (done !== 1'b1 && n < 2000) begin
      wv = 3'((n - 1) / 10);
      tests++; if ({a_out, b_out, c_out} !== wv || busy !== 1'b1) begin
        fails++; $display("FAIL sweep_vec n=%0d got %b busy=%b want %b busy=1", n, {a_out, b_out, c_out}, busy, wv);
      end
      @(negedge clk);
      n++;
    end
    tests++; if (n !== 81) begin fails++; $display("FAIL maj_latency got %0d want 81", n); end
    e = sb.pop_front();
    tests++; if (table_out !== e.tbl || table_out !== 8'hE8) begin fails++; $display("FAIL maj_table got %h want %h", table_out, e.tbl); end
    tests++; if (pass !== e.pas) begin fails++; $display("FAIL maj_pass got %b want %b", pass, e.pas); end
    tests++; if ({a_out, b_out, c_out} !== 3'b111 || busy !== 1'b0) begin fails++; $display("FAIL fin_vec got %b busy=%b want 111 busy=0", {a_out, b_out, c_out}, busy); end
    @(negedge clk);
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL done_width got %b want 0", done); end
    tests++; if ({a_out, b_out, c_out} !== 3'b000) begin fails++; $display("FAIL idle_vec got %b want 000", {a_out, b_out, c_out}); end
    tests++; if (table_out !== 8'hE8 || pass !== 1'b1) begin fails++; $display("FAIL hold got %h/%b want e8/1", table_out, pass); end
  endtask

  task automatic test_mismatch();
    int lat;
    pulse_start(8'hE9, 1'b0);
    exp_table = 8'hE8;
    wait_done(lat);
    tests++; if (lat !== 81) begin fails++; $display("FAIL mis_latency got %0d want 81", lat); end
    e = sb.pop_front();
    tests++; if (table_out !== e.tbl) begin fails++; $display("FAIL mis_table got %h want %h", table_out, e.tbl); end
    tests++; if (pass !== e.pas) begin fails++; $display("FAIL mis_pass got %b want %b", pass, e.pas); end
    @(negedge clk);
  endtask

  task automatic test_dwell2();
    int n;
    @(negedge clk);
    exp2   = 8'hFF;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    n = 1;
    while (done2 !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    tests++; if (n !== 17) begin fails++; $display("FAIL d2_latency got %0d want 17", n); end
    tests++; if (table2 !== 8'hFF || pass2 !== 1'b1) begin fails++; $display("FAIL d2_result got %h/%b want ff/1", table2, pass2); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int lat;
    int seen;
    pulse_start(8'hE8, 1'b1);
    repeat (34) @(negedge clk);
    tests++; if ({a_out, b_out, c_out} !== 3'b011) begin fails++; $display("FAIL mid_vec got %b want 011", {a_out, b_out, c_out}); end
    #2 rst_n = 1'b0;
    #1;
    void'(sb.pop_front());
    tests++; if ({a_out, b_out, c_out, busy, done} !== 5'b0 || table_out !== 8'h00) begin
      fails++; $display("FAIL abort got vec=%b busy=%b done=%b tbl=%h want zeros", {a_out, b_out, c_out}, busy, done, table_out);
    end
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    rst_n = 1'b1;
    repeat (60) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    tests++; if (seen !== 0) begin fails++; $display("FAIL abort_done got %0d want 0", seen); end
    pulse_start(8'hE8, 1'b1);
    wait_done(lat);
    e = sb.pop_front();
    tests++; if (lat !== 81 || table_out !== e.tbl || pass !== e.pas) begin
      fails++; $display("FAIL restart got lat=%0d tbl=%h pass=%b want 81/%h/%b", lat, table_out, pass, e.tbl, e.pas);
    end
    @(negedge clk);
  endtask

  task automatic test_restart_ignored();
    int n;
    pulse_start(8'hE8, 1'b1);
    n = 1;
    while (done !== 1'b1 && n < 2000) begin
      start = (n == 55);
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    tests++; if (n !== 81) begin fails++; $display("FAIL ignore_latency got %0d want 81", n); end
    e = sb.pop_front();
    tests++; if (table_out !== e.tbl || pass !== e.pas) begin fails++; $display("FAIL ignore_result got %h/%b want %h/%b", table_out, pass, e.tbl, e.pas); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int lat;
    int m;
    @(negedge clk);
    exp_table = 8'hE8;
    start     = 1'b1;
    sb.push_back('{tbl: maj_table(), pas: 1'b1});
    @(negedge clk);
    wait_done(lat);
    e = sb.pop_front();
    tests++; if (lat !== 81 || table_out !== e.tbl) begin fails++; $display("FAIL b2b_first got lat=%0d tbl=%h want 81/%h", lat, table_out, e.tbl); end
    sb.push_back('{tbl: maj_table(), pas: 1'b1});
    m = 0;
    while (busy !== 1'b1 && m < 10) begin
      @(negedge clk);
      m++;
    end
    tests++; if (m !== 2) begin fails++; $display("FAIL b2b_gap got %0d want 2", m); end
    start = 1'b0;
    wait_done(lat);
    e = sb.pop_front();
    tests++; if (lat !== 81 || table_out !== e.tbl || pass !== e.pas) begin
      fails++; $display("FAIL b2b_second got lat=%0d tbl=%h pass=%b want 81/%h/%b", lat, table_out, pass, e.tbl, e.pas);
    end
    @(negedge clk);
  endtask

  task automatic test_glitch();
    int lat;
    glitch_en = 1'b1;
    pulse_start(8'hE8, 1'b1);
    wait_done(lat);
    e = sb.pop_front();
    tests++; if (lat !== 81 || table_out !== e.tbl || pass !== e.pas) begin
      fails++; $display("FAIL glitch got lat=%0d tbl=%h pass=%b want 81/%h/%b", lat, table_out, pass, e.tbl, e.pas);
    end
    glitch_en = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    start     = 1'b0;
    start2    = 1'b0;
    exp_table = 8'h00;
    exp2      = 8'h00;
    test_reset();
    test_majority();
    test_mismatch();
    test_dwell2();
    test_reset_mid();
    test_restart_ignored();
    test_back_to_back();
    test_glitch();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
